// File: rtl/i2s_serializer.sv
// rtl/i2s_serializer.sv - I2S transmitter: 16-bit stereo samples in 32-bit slots, MSB first
module i2s_serializer #(
    parameter int CLKDIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ena,
    input  logic [15:0] d_l,
    input  logic [15:0] d_r,
    output logic        sample_stb,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  divcnt_q, divcnt_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic        bclk_q, bclk_d;
    logic        lrclk_q, lrclk_d;
    logic        sdata_q, sdata_d;
    logic        stb_q, stb_d;
    logic [15:0] shl_q, shl_d;
    logic [15:0] shr_q, shr_d;

    // Bit value for the slot that the next falling bclk edge will open.
    logic [5:0]  bit_nxt;
    logic [4:0]  slot;
    logic [15:0] word;
    logic [3:0]  bit_idx;
    logic        slot_bit;

    assign bit_nxt  = bitcnt_q + 6'd1;
    assign slot     = bit_nxt[4:0];
    assign word     = bit_nxt[5] ? shr_q : shl_q;
    assign bit_idx  = 4'(5'd16 - slot);
    assign slot_bit = (slot != 5'd0 && slot <= 5'd16) ? word[bit_idx] : 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            divcnt_q <= '0;
            bitcnt_q <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            stb_q    <= 1'b0;
            shl_q    <= '0;
            shr_q    <= '0;
        end else begin
            state_q  <= state_d;
            divcnt_q <= divcnt_d;
            bitcnt_q <= bitcnt_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            stb_q    <= stb_d;
            shl_q    <= shl_d;
            shr_q    <= shr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        divcnt_d = divcnt_q;
        bitcnt_d = bitcnt_q;
        bclk_d   = bclk_q;
        lrclk_d  = lrclk_q;
        sdata_d  = sdata_q;
        stb_d    = 1'b0;
        shl_d    = shl_q;
        shr_d    = shr_q;
        case (state_q)
            IDLE: begin
                divcnt_d = '0;
                bitcnt_d = '0;
                bclk_d   = 1'b0;
                lrclk_d  = 1'b0;
                sdata_d  = 1'b0;
                if (ena) begin
                    state_d = RUN;
                    shl_d   = d_l;
                    shr_d   = d_r;
                    stb_d   = 1'b1;
                end
            end
            RUN: begin
                if (!ena) begin
                    // Abandon the frame; the next enable starts a fresh one.
                    state_d  = IDLE;
                    divcnt_d = '0;
                    bitcnt_d = '0;
                    bclk_d   = 1'b0;
                    lrclk_d  = 1'b0;
                    sdata_d  = 1'b0;
                end else if (divcnt_q == DIV_LAST) begin
                    divcnt_d = '0;
                    bclk_d   = ~bclk_q;
                    if (bclk_q) begin
                        bitcnt_d = bit_nxt;
                        lrclk_d  = bit_nxt[5];
                        sdata_d  = slot_bit;
                        if (bit_nxt == 6'd0) begin
                            shl_d = d_l;
                            shr_d = d_r;
                            stb_d = 1'b1;
                        end
                    end
                end else begin
                    divcnt_d = divcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sample_stb = stb_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = sdata_q;

endmodule
